// File: rtl/seq_sorter_if.sv
// seq_sorter_if: in/out valid-ready stream bundle for seq_sorter.
// slave = sorter side, master = producer/consumer side.
interface seq_sorter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/seq_sorter.sv
// seq_sorter: loads a burst of up to DEPTH words, sorts it with an
// odd-even transposition network, streams it out ascending.
// Ports: clk, rst (sync, active-high), bus (seq_sorter_if.slave).
module seq_sorter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  seq_sorter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    OUT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] nxt [DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    rd;
  logic [AW-1:0]    ph;
  logic             acc;
  logic             hs;
  logic             ov;

  assign ov            = (state == OUT);
  assign bus.in_ready  = (state == LOAD) && !rst;
  assign bus.out_valid = ov;
  assign bus.out_last  = ov && (rd == cnt - CW'(1));
  assign bus.out_data  = ov ? mem[rd[AW-1:0]] : '0;

  assign acc = bus.in_valid && bus.in_ready;
  assign hs  = ov && bus.out_ready;

  // Pairs within one phase never overlap, so every swap
  // reads the current contents only.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = mem[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if ((((i % 2) != 0) == ph[0])
          && (mem[i] > mem[i+1])) begin
        nxt[i]   = mem[i+1];
        nxt[i+1] = mem[i];
      end
    end
  end

  // All-ones pads sort to the top, leaving the loaded
  // words ascending in slots 0..cnt-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
      rd    <= '0;
      ph    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '1;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (acc) begin
            mem[cnt[AW-1:0]] <= bus.in_data;
            cnt <= cnt + CW'(1);
            if (bus.in_last ||
                (cnt == CW'(DEPTH - 1))) begin
              state <= SORT;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= nxt[i];
          end
          if (ph == AW'(DEPTH - 1)) begin
            ph    <= '0;
            rd    <= '0;
            state <= OUT;
          end else begin
            ph <= ph + AW'(1);
          end
        end
        OUT: begin
          if (hs) begin
            rd <= rd + CW'(1);
            if (bus.out_last) begin
              state <= LOAD;
              cnt   <= '0;
              for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '1;
              end
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_sorter.sv
// tb_seq_sorter: directed bursts with a scoreboard of
// reference-sorted words, checked as the sorter emits them.
module tb_seq_sorter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_sorter_if #(.WIDTH(32)) b ();

  seq_sorter #(
    .WIDTH(32),
    .DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  int          passed  = 0;
  int          total   = 0;
  int          bad_rdy = 0;
  logic [31:0] exp_q [$];
  logic [31:0] stim [8];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input int n, input bit mark_last,
                      input bit stall);
    logic [31:0] s [$];
    logic [31:0] t;
    int          tries;
    bit          acc;
    for (int i = 0; i < n; i++) s.push_back(stim[i]);
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (s[j-1] > s[j]) begin
          t      = s[j];
          s[j]   = s[j-1];
          s[j-1] = t;
        end
      end
    end
    foreach (s[i]) exp_q.push_back(s[i]);
    for (int i = 0; i < n; i++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 200) begin
        @(negedge clk);
        b.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        b.in_data  = stim[i];
        b.in_last  = mark_last && (i == n - 1);
        acc        = b.in_valid && b.in_ready;
        @(posedge clk);
        tries++;
      end
      if (!acc) begin
        chk("in_accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic recv(input int n, input int bp_k,
                      input int bp_n, input int stop_at);
    int sc;
    sc      = 0;
    bad_rdy = 0;
    @(negedge clk);
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
    while (b.out_valid !== 1'b1 && sc < 100) begin
      if (b.in_ready !== 1'b0) bad_rdy++;
      sc++;
      @(negedge clk);
    end
    chk("out_valid_rise", 32'(b.out_valid), 32'd1);
    chk("sort_cycles", 32'(sc), 32'd8);
    for (int k = 0; k < n; k++) begin
      if (k == stop_at) return;
      if (k == bp_k) begin
        b.out_ready = 1'b0;
        repeat (bp_n) begin
          chk("bp_valid", 32'(b.out_valid), 32'd1);
          chk("bp_data", b.out_data, exp_q[0]);
          @(negedge clk);
        end
      end
      chk("out_valid", 32'(b.out_valid), 32'd1);
      chk("out_data", b.out_data, exp_q.pop_front());
      chk("out_last", 32'(b.out_last), 32'(k == n - 1));
      if (b.in_ready !== 1'b0) bad_rdy++;
      b.out_ready = 1'b1;
      @(negedge clk);
    end
    b.out_ready = 1'b0;
    chk("in_ready_blocked", 32'(bad_rdy), 32'd0);
    chk("out_valid_drop", 32'(b.out_valid), 32'd0);
    chk("in_ready_back", 32'(b.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    b.in_valid  = 1'b0;
    b.in_data   = '0;
    b.in_last   = 1'b0;
    b.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(b.out_valid), 32'd0);
    chk("rst_out_last", 32'(b.out_last), 32'd0);
    chk("rst_out_data", b.out_data, 32'd0);
    chk("rst_in_ready", 32'(b.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(b.in_ready), 32'd1);

    stim = '{5, 3, 9, 1, 7, 2, 8, 6};
    send(8, 1'b1, 1'b0);
    recv(8, -1, 0, 8);

    stim = '{32'hFFFF_FFFF, 4, 4, 0, 0, 0, 0, 0};
    send(3, 1'b1, 1'b0);
    recv(3, -1, 0, 3);

    stim = '{42, 0, 0, 0, 0, 0, 0, 0};
    send(1, 1'b1, 1'b0);
    recv(1, -1, 0, 1);

    stim = '{20, 15, 30, 25, 0, 0, 0, 0};
    send(4, 1'b1, 1'b0);
    recv(4, 1, 3, 4);

    stim = '{100, 90, 80, 70, 60, 50, 40, 30};
    send(8, 1'b1, 1'b0);
    recv(8, -1, 0, 2);
    b.out_ready = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(b.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(b.in_ready), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_back", 32'(b.in_ready), 32'd1);
    stim = '{10, 0, 0, 0, 0, 0, 0, 0};
    send(2, 1'b1, 1'b0);
    recv(2, -1, 0, 2);

    for (int i = 0; i < 8; i++) stim[i] = $urandom;
    send(8, 1'b0, 1'b1);
    recv(8, -1, 0, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
